// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the core's address-map checks.
package dmem_pkg;
  localparam int unsigned DMEM_DATA_W    = 32;
  localparam int unsigned DMEM_BE_W      = 4;
  localparam logic [31:0] DMEM_BASE_ADDR = 32'h10010000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } dmem_state_e;
endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory req/ack bus between the CPU (master) and the memory responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                   req;
  logic                   we;
  logic [31:0]            addr;
  logic [DMEM_BE_W-1:0]   be;
  logic [DMEM_DATA_W-1:0] wdata;
  logic                   ack;
  logic [DMEM_DATA_W-1:0] rdata;
  logic                   err;

  modport master (output req, we, addr, be, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-lane write enables and registered read; contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [DMEM_BE_W-1:0]   be,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);
  logic [DMEM_DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < DMEM_BE_W; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: accepts one load/store per req, inserts WAIT_CYCLES wait states, and
// answers with a one-cycle ack; misaligned or out-of-range accesses complete with err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);
  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

  dmem_state_e            state;
  logic [3:0]             cnt;
  logic                   lat_we;
  logic [IDX_W-1:0]       lat_idx;
  logic [DMEM_BE_W-1:0]   lat_be;
  logic [DMEM_DATA_W-1:0] lat_wdata;
  logic                   ack_q;
  logic                   err_q;
  logic                   rd_valid;

  logic                   addr_bad;
  logic                   resp_now;
  logic [IDX_W-1:0]       idx_in;
  logic                   mem_en;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_idx;
  logic [DMEM_BE_W-1:0]   mem_be;
  logic [DMEM_DATA_W-1:0] mem_wdata;
  logic [DMEM_DATA_W-1:0] ram_rdata;

  // Base is word-aligned, so subtracting on the index bits alone equals (addr-base)>>2 truncated.
  always_comb begin
    addr_bad = (bus.addr[1:0] != 2'b00) || (bus.addr < BASE_ADDR) ||
               ({1'b0, bus.addr} >= ADDR_END);
    idx_in   = bus.addr[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
    resp_now = addr_bad || NO_WAIT;
  end

  // The RAM is touched on the edge entering RESP: straight from the bus with no wait states,
  // otherwise from the values latched at acceptance.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = lat_we;
    mem_idx   = lat_idx;
    mem_be    = lat_be;
    mem_wdata = lat_wdata;
    if (state == S_IDLE) begin
      mem_en    = bus.req && resp_now && !addr_bad;
      mem_we    = bus.we;
      mem_idx   = idx_in;
      mem_be    = bus.be;
      mem_wdata = bus.wdata;
    end else if (state == S_WAIT) begin
      mem_en    = (cnt == '0);
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ack_q    <= 1'b0;
          err_q    <= 1'b0;
          rd_valid <= 1'b0;
          if (bus.req) begin
            lat_we    <= bus.we;
            lat_idx   <= idx_in;
            lat_be    <= bus.be;
            lat_wdata <= bus.wdata;
            if (resp_now) begin
              state    <= S_RESP;
              ack_q    <= 1'b1;
              err_q    <= addr_bad;
              rd_valid <= !addr_bad && !bus.we;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state    <= S_RESP;
            ack_q    <= 1'b1;
            err_q    <= 1'b0;
            rd_valid <= !lat_we;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          ack_q    <= 1'b0;
          err_q    <= 1'b0;
          rd_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM read register has no reset, so rdata is qualified by a reset-able flag.
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rd_valid ? ram_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus scoreboard, with wait-state and
// zero-wait instances.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_responder_if ifa();
  dmem_responder_if ifb();

  dmem_responder #(
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h10010000),
    .WAIT_CYCLES (2)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  dmem_responder #(
    .DEPTH_WORDS (256),
    .BASE_ADDR   (32'h10010000),
    .WAIT_CYCLES (0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every ack pops one expected response and checks timing and data.
  always @(negedge clk) begin
    if (ifa.ack === 1'b1) begin
      chk("a_ack_gap", {31'b0, prev_a}, 32'd0);
      if (qa.size() == 0) begin
        chk("a_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_err", {31'b0, ifa.err}, {31'b0, e.err});
        chk("a_rdata", ifa.rdata, e.rdata);
        chk("a_ack_cycle", cyc, e.cyc);
      end
    end
    prev_a = (ifa.ack === 1'b1);
  end

  always @(negedge clk) begin
    if (ifb.ack === 1'b1) begin
      chk("b_ack_gap", {31'b0, prev_b}, 32'd0);
      if (qb.size() == 0) begin
        chk("b_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_err", {31'b0, ifb.err}, {31'b0, e.err});
        chk("b_rdata", ifb.rdata, e.rdata);
        chk("b_ack_cycle", cyc, e.cyc);
      end
    end
    prev_b = (ifb.ack === 1'b1);
  end

  task automatic wait_qa_empty();
    for (int i = 0; i < 40 && qa.size() != 0; i++) @(negedge clk);
    if (qa.size() != 0) begin
      total++;
      bad++;
      $display("FAIL a_timeout got=%0d pending want=0", qa.size());
      qa.delete();
    end
  endtask

  // One transaction on the 2-wait-state instance; inputs are scrambled right after acceptance.
  task automatic xact_a(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] er, input logic ee);
    exp_t e;
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = w; ifa.addr = a; ifa.be = b; ifa.wdata = d;
    e.rdata = er;
    e.err   = ee;
    e.cyc   = cyc + 1 + (ee ? 0 : 2);
    qa.push_back(e);
    @(negedge clk);
    ifa.req   = 1'b0;
    ifa.we    = ~w;
    ifa.addr  = 32'h10010000 + 4 * $urandom_range(0, 255);
    ifa.be    = 4'($urandom);
    ifa.wdata = $urandom;
    wait_qa_empty();
  endtask

  vec_t vt[17];
  vec_t vb[6];

  initial begin
    ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.be = '0; ifa.wdata = '0;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.be = '0; ifb.wdata = '0;

    vt[0]  = '{1'b1, 32'h10010008, 4'hF,    32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10010008, 4'h0,    32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h10010010, 4'hF,    32'h11223344, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h10010010, 4'b0101, 32'hAABBCCDD, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h10010010, 4'h0,    32'h0,        32'h11BB33DD, 1'b0};
    vt[5]  = '{1'b1, 32'h10010000, 4'hF,    32'h00000000, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h10010002, 4'h0,    32'h0,        32'h0,        1'b1};
    vt[7]  = '{1'b1, 32'h10010400, 4'hF,    32'h12345678, 32'h0,        1'b1};
    vt[8]  = '{1'b0, 32'h10010000, 4'h0,    32'h0,        32'h00000000, 1'b0};
    vt[9]  = '{1'b1, 32'h1000FFFC, 4'hF,    32'h87654321, 32'h0,        1'b1};
    vt[10] = '{1'b1, 32'h100103FC, 4'hF,    32'hA5A5A5A5, 32'h0,        1'b0};
    vt[11] = '{1'b0, 32'h100103FC, 4'h0,    32'h0,        32'hA5A5A5A5, 1'b0};
    vt[12] = '{1'b1, 32'h10010014, 4'hF,    32'h13572468, 32'h0,        1'b0};
    vt[13] = '{1'b1, 32'h10010014, 4'h0,    32'hFFFFFFFF, 32'h0,        1'b0};
    vt[14] = '{1'b0, 32'h10010014, 4'h0,    32'h0,        32'h13572468, 1'b0};
    vt[15] = '{1'b0, 32'h100103FD, 4'h0,    32'h0,        32'h0,        1'b1};
    vt[16] = '{1'b1, 32'h10010020, 4'hF,    32'h00000000, 32'h0,        1'b0};

    vb[0] = '{1'b1, 32'h10010100, 4'hF, 32'h0BADF00D, 32'h0,        1'b0};
    vb[1] = '{1'b1, 32'h10010104, 4'hF, 32'h600DCAFE, 32'h0,        1'b0};
    vb[2] = '{1'b1, 32'h10010108, 4'hF, 32'h12345678, 32'h0,        1'b0};
    vb[3] = '{1'b0, 32'h10010100, 4'h0, 32'h0,        32'h0BADF00D, 1'b0};
    vb[4] = '{1'b0, 32'h10010104, 4'h0, 32'h0,        32'h600DCAFE, 1'b0};
    vb[5] = '{1'b0, 32'h10010108, 4'h0, 32'h0,        32'h12345678, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_a_ack", {31'b0, ifa.ack}, 32'd0);
    chk("rst_a_err", {31'b0, ifa.err}, 32'd0);
    chk("rst_a_rdata", ifa.rdata, 32'd0);
    chk("rst_b_ack", {31'b0, ifb.ack}, 32'd0);
    chk("rst_b_rdata", ifb.rdata, 32'd0);
    rst_n = 1'b1;

    foreach (vt[i])
      xact_a(vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);

    // Reset while a store sits in WAIT: it must never commit.
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 32'h10010020; ifa.be = 4'hF; ifa.wdata = 32'hCAFEF00D;
    @(negedge clk);
    ifa.req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_ack", {31'b0, ifa.ack}, 32'd0);
    chk("rstw_rdata", ifa.rdata, 32'd0);
    repeat (3) @(negedge clk);
    chk("rstw_hold_ack", {31'b0, ifa.ack}, 32'd0);
    rst_n = 1'b1;
    xact_a(1'b0, 32'h10010020, 4'h0, 32'h0, 32'h00000000, 1'b0);
    xact_a(1'b0, 32'h10010008, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);

    // Reset while ack is high: outputs drop asynchronously.
    begin
      exp_t e;
      @(negedge clk);
      ifa.req = 1'b1; ifa.we = 1'b0; ifa.addr = 32'h10010008;
      e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.cyc = cyc + 3;
      qa.push_back(e);
      @(negedge clk);
      ifa.req = 1'b0;
      for (int i = 0; i < 10 && ifa.ack !== 1'b1; i++) @(negedge clk);
      chk("rstr_ack_seen", {31'b0, ifa.ack}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstr_ack", {31'b0, ifa.ack}, 32'd0);
      chk("rstr_rdata", ifa.rdata, 32'd0);
      chk("rstr_err", {31'b0, ifa.err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      qa.delete();
    end

    // Back-to-back on the zero-wait instance with req held high throughout.
    begin
      int unsigned first;
      @(negedge clk);
      first = cyc + 1;
      for (int k = 0; k < 6; k++) begin
        exp_t e;
        ifb.req = 1'b1; ifb.we = vb[k].we; ifb.addr = vb[k].addr;
        ifb.be = vb[k].be; ifb.wdata = vb[k].wdata;
        e.rdata = vb[k].exp_rdata; e.err = vb[k].exp_err; e.cyc = first + 2 * k;
        qb.push_back(e);
        @(negedge clk);
        @(negedge clk);
      end
      ifb.req = 1'b0;
      for (int i = 0; i < 20 && qb.size() != 0; i++) @(negedge clk);
      if (qb.size() != 0) begin
        total++;
        bad++;
        $display("FAIL b_timeout got=%0d pending want=0", qb.size());
        qb.delete();
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the CPU data-memory port: a word-organised, byte-enabled data RAM that answers load/store requests from the processor with a req/ack handshake and a programmable number of wait states. It replaces the zero-latency combinational data memory so the core (or a future multi-cycle/pipelined core) can be tested against a realistic slave. It also flags misaligned and out-of-range accesses with an error response instead of corrupting state.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words stored; power of two.
- `BASE_ADDR`, 32'h10010000: byte address of word 0; the MIPS data segment.
- `WAIT_CYCLES`, 2: wait states inserted between acceptance and response; 0–15 legal.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 1: initiator request; held high until `ack`.
- `we` input 1: 1 = store, 0 = load.
- `addr` input 32: byte address; must be word-aligned.
- `be` input 4: byte enables for stores, bit i ↔ `wdata[8i+7:8i]`; ignored on loads.
- `wdata` input 32: store data.
- `ack` output 1: one-cycle response strobe.
- `rdata` output 32: load data, valid while `ack`=1.
- `err` output 1: error qualifier, valid while `ack`=1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a rising edge with `req`=1, latch `we`, `addr`, `be`, `wdata`.
  - Error check at acceptance: `addr[1:0]`≠0, or `addr` < BASE_ADDR, or `addr` ≥ BASE_ADDR+4·DEPTH_WORDS → error transaction.
  - Next state is WAIT when WAIT_CYCLES>0 and no error; otherwise RESP.
- WAIT: a down-counter loaded with WAIT_CYCLES−1 at acceptance decrements each cycle. Move to RESP on the edge where the counter is 0.
- RESP: `ack`=1 for exactly one cycle, then unconditionally return to IDLE.
- Index: `(addr − BASE_ADDR) >> 2`, truncated to log2(DEPTH_WORDS) bits.
- Store: on the edge entering RESP, write every byte lane with `be[i]`=1; lanes with `be[i]`=0 keep their contents. `be`=0 completes as a legal no-op. `rdata`=0 during a store response.
- Load: the word at the index is registered on the edge entering RESP. Bytes are not shifted; lane selection is the core's job.
- Error transaction: no write, `rdata`=0, `err`=1 with `ack`. Error responses skip WAIT regardless of WAIT_CYCLES.
- `req` is sampled only in IDLE. If `req` is still high in the cycle after `ack`, the next edge starts a new transaction (back-to-back allowed, one idle cycle minimum between responses). Changes to inputs during WAIT/RESP are ignored.
- Memory contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset values: `ack`=0, `err`=0, `rdata`=0, state=IDLE, counter=0.
- Latency: if `req` is accepted at edge N, `ack` is high in the cycle after edge N+WAIT_CYCLES. For WAIT_CYCLES=0 or an error, that is the cycle after edge N.
- Throughput: one transaction per WAIT_CYCLES+2 cycles with `req` held continuously.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-transaction: return immediately to IDLE with outputs at reset values. A store not yet committed (still in WAIT) is dropped. A store committed on an edge before reset persists.
- Reset released: the first edge with `rst_n`=1 and `req`=1 is accepted normally.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE/WAIT/RESP);
  - `DMEM_DATA_W`=32 and `DMEM_BE_W`=4;
  - the default BASE_ADDR constant, shared with the core's address-map checks.
- Sub-module `dmem_array`: synchronous single-port RAM with byte-lane write enables (clk, en, we, be, idx, wdata, rdata) and no reset. The FSM, error decode and counter live in the top.

## Test plan
- Store then load, WAIT_CYCLES=2:
  - store 32'hDEADBEEF at 32'h10010008 with `be`=4'hF → `ack` 3 cycles after acceptance, `err`=0;
  - load from the same address → `rdata`=32'hDEADBEEF.
- Partial write:
  - word holding 32'h11223344 at 32'h10010010; store 32'hAABBCCDD with `be`=4'b0101;
  - load the word → 32'h11BB33DD.
- Errors:
  - load at 32'h10010002 → `ack`=1 with `err`=1 and `rdata`=0, one cycle after acceptance;
  - store at 32'h10010400 (DEPTH_WORDS=256, out of range) → `err`=1; a following load at 32'h10010000 is unchanged.
- Back-to-back: `req` held high for 3 loads, WAIT_CYCLES=0 → `ack` pulses every 2nd cycle, each with correct data, never two consecutive `ack` cycles.
- Reset mid-store: assert `rst_n`=0 during WAIT of a store of 32'hCAFEF00D to 32'h10010020 (previously 32'h0) → outputs go to 0 immediately; after release, a load returns 32'h0.
- Ignored inputs: change `addr` and `wdata` during WAIT → the response and the stored word reflect the values latched at acceptance.
